// File: rtl/nes_pad_responder.sv
// NES pad emulator: answers a host controller reader's latch/clock with a serial button snapshot.
// Optional autofire for A/B is built when NES_PAD_TURBO_EN is defined.
module nes_pad_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TURBO_POLLS    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  buttons,
  input  logic        turbo_a,
  input  logic        turbo_b,
  input  logic        latch,
  input  logic        ctrl_clk,
  output logic        data,
  output logic        host_active,
  output logic [15:0] poll_count
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] latch_sync, cclk_sync;
  logic                   latch_d, cclk_d;
  logic                   latch_s, cclk_s, latch_rise, cclk_rise;
  logic [WD_W-1:0]        wd_cnt;
  logic                   seen;
  logic [7:0]             sr, load_val;
  logic [2:0]             bit_cnt;
  state_t                 state;

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign cclk_s     = cclk_sync[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_d;
  assign cclk_rise  = cclk_s & ~cclk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_sync <= '0;
      cclk_sync  <= '0;
      latch_d    <= 1'b0;
      cclk_d     <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch};
      cclk_sync  <= {cclk_sync[SYNC_STAGES-2:0], ctrl_clk};
      latch_d    <= latch_s;
      cclk_d     <= cclk_s;
    end
  end

  // Watchdog saturates so host_active stays low until the next latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt     <= '0;
      seen       <= 1'b0;
      poll_count <= '0;
    end else if (latch_rise) begin
      wd_cnt     <= '0;
      seen       <= 1'b1;
      poll_count <= poll_count + 16'd1;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign host_active = seen && (wd_cnt < WD_MAX);

`ifdef NES_PAD_TURBO_EN
  localparam int TP_W = $clog2(TURBO_POLLS + 1);
  logic [TP_W-1:0] turbo_cnt;
  logic            turbo_phase;

  // The phase flips on the first poll of a new period, so a whole period shares one phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turbo_cnt   <= '0;
      turbo_phase <= 1'b0;
    end else if (latch_rise) begin
      if (turbo_cnt == TP_W'(TURBO_POLLS)) begin
        turbo_cnt   <= TP_W'(1);
        turbo_phase <= ~turbo_phase;
      end else begin
        turbo_cnt <= turbo_cnt + TP_W'(1);
      end
    end
  end

  assign load_val = ~(buttons & ~{turbo_phase & turbo_a, turbo_phase & turbo_b, 6'b0});
`else
  logic unused_turbo;
  assign unused_turbo = turbo_a ^ turbo_b;
  assign load_val     = ~buttons;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sr      <= 8'hFF;
      bit_cnt <= '0;
      data    <= 1'b1;
    end else begin
      case (state)
        IDLE:    data <= 1'b1;
        DONE:    data <= 1'b0;
        default: data <= sr[7];
      endcase
      // Latch has priority over everything, including a same-cycle clock edge.
      if (latch_s) begin
        state   <= LOAD;
        sr      <= load_val;
        bit_cnt <= '0;
      end else begin
        case (state)
          LOAD: state <= SHIFT;
          SHIFT: if (cclk_rise) begin
            sr      <= {sr[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= DONE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nes_pad_responder.sv
// Scoreboard bench for nes_pad_responder: expected data bits are queued at latch time, popped at read time.
module tb_nes_pad_responder;
  localparam int SYNC = 2;
  localparam int TMO  = 200;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [7:0]  buttons = '0;
  logic        turbo_a = 0, turbo_b = 0;
  logic        latch = 0, ctrl_clk = 0;
  logic        data, host_active;
  logic [15:0] poll_count;

  int          total = 0, bad = 0;
  logic [15:0] poll_exp = 0;
  logic        sb[$];

  nes_pad_responder #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .TURBO_POLLS(2)) dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .turbo_a(turbo_a), .turbo_b(turbo_b),
    .latch(latch), .ctrl_clk(ctrl_clk), .data(data), .host_active(host_active),
    .poll_count(poll_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_latch();
    latch = 1; hold(6);
    latch = 0; hold(6);
    poll_exp++;
  endtask

  task automatic push_frame(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sb.push_back(~b[i]);
  endtask

  // Samples the bit currently presented, then gives one host clock pulse.
  task automatic read_bit(output logic b);
    b = data;
    ctrl_clk = 1; hold(6);
    ctrl_clk = 0; hold(6);
  endtask

  task automatic test_reset();
    logic [17:0] got;
    got = {data, host_active, poll_count};
    total++;
    if (got !== {1'b1, 1'b0, 16'h0}) begin
      bad++;
      $display("FAIL reset got data/act/poll=%b/%b/%h exp 1/0/0000", got[17], got[16], got[15:0]);
    end
  endtask

  task automatic test_basic();
    logic b, e;
    buttons = 8'b1000_0001;
    do_latch();
    push_frame(buttons);
    for (int i = 0; i < 8; i++) begin
      read_bit(b); e = sb.pop_front(); total++;
      if (b !== e) begin bad++; $display("FAIL basic_bit%0d got=%b exp=%b", i, b, e); end
    end
    total++;
    if (poll_count !== poll_exp) begin bad++; $display("FAIL basic_poll got=%0d exp=%0d", poll_count, poll_exp); end
    total++;
    if (host_active !== 1'b1) begin bad++; $display("FAIL basic_active got=%b exp=1", host_active); end
  endtask

  task automatic test_done();
    logic b;
    for (int i = 0; i < 3; i++) begin
      read_bit(b); total++;
      if (b !== 1'b0) begin bad++; $display("FAIL done_extra%0d got=%b exp=0", i, b); end
    end
    total++;
    if (data !== 1'b0) begin bad++; $display("FAIL done_after got=%b exp=0", data); end
    buttons = 8'h00;
    do_latch();
    total++;
    if (data !== 1'b1) begin bad++; $display("FAIL done_relatch got=%b exp=1", data); end
  endtask

  task automatic test_abort();
    logic b, e;
    buttons = 8'h55;
    do_latch();
    push_frame(buttons);
    for (int i = 0; i < 3; i++) begin
      read_bit(b); e = sb.pop_front(); total++;
      if (b !== e) begin bad++; $display("FAIL abort_pre%0d got=%b exp=%b", i, b, e); end
    end
    sb.delete();
    buttons = 8'h40;
    do_latch();
    push_frame(buttons);
    for (int i = 0; i < 8; i++) begin
      read_bit(b); e = sb.pop_front(); total++;
      if (b !== e) begin bad++; $display("FAIL abort_bit%0d got=%b exp=%b", i, b, e); end
    end
  endtask

  task automatic test_same_cycle();
    logic b, e;
    buttons = 8'hA5;
    latch = 1; ctrl_clk = 1; hold(6);
    latch = 0; ctrl_clk = 0; hold(6);
    poll_exp++;
    push_frame(buttons);
    for (int i = 0; i < 8; i++) begin
      read_bit(b); e = sb.pop_front(); total++;
      if (b !== e) begin bad++; $display("FAIL same_bit%0d got=%b exp=%b", i, b, e); end
    end
    total++;
    if (data !== 1'b0) begin bad++; $display("FAIL same_done got=%b exp=0", data); end
  endtask

  task automatic test_back_to_back();
    logic b, e;
    for (int f = 0; f < 4; f++) begin
      buttons = 8'($urandom);
      do_latch();
      push_frame(buttons);
      for (int i = 0; i < 8; i++) begin
        if (i == 2) buttons = ~buttons;
        read_bit(b); e = sb.pop_front(); total++;
        if (b !== e) begin bad++; $display("FAIL b2b_f%0d_bit%0d got=%b exp=%b", f, i, b, e); end
      end
    end
    total++;
    if (poll_count !== poll_exp) begin bad++; $display("FAIL b2b_poll got=%0d exp=%0d", poll_count, poll_exp); end
  endtask

  task automatic test_timeout();
    do_latch();
    hold(130);
    total++;
    if (host_active !== 1'b1) begin bad++; $display("FAIL tmo_before got=%b exp=1", host_active); end
    hold(80);
    total++;
    if (host_active !== 1'b0) begin bad++; $display("FAIL tmo_expired got=%b exp=0", host_active); end
    latch = 1; hold(SYNC + 2);
    total++;
    if (host_active !== 1'b1) begin bad++; $display("FAIL tmo_restore got=%b exp=1", host_active); end
    hold(4); latch = 0; hold(6);
    poll_exp++;
    total++;
    if (poll_count !== poll_exp) begin bad++; $display("FAIL tmo_poll got=%0d exp=%0d", poll_count, poll_exp); end
  endtask

  task automatic test_reset_mid();
    logic b, e;
    buttons = 8'h3C;
    do_latch();
    for (int i = 0; i < 3; i++) read_bit(b);
    ctrl_clk = 1; #3;
    rst_n = 0; #1;
    total++;
    if ({data, host_active, poll_count} !== {1'b1, 1'b0, 16'h0}) begin
      bad++;
      $display("FAIL rst_mid got data/act/poll=%b/%b/%h exp 1/0/0000", data, host_active, poll_count);
    end
    ctrl_clk = 0; hold(3);
    rst_n = 1; hold(2);
    poll_exp = 0;
    buttons = 8'h18;
    do_latch();
    push_frame(buttons);
    for (int i = 0; i < 8; i++) begin
      read_bit(b); e = sb.pop_front(); total++;
      if (b !== e) begin bad++; $display("FAIL rst_resume_bit%0d got=%b exp=%b", i, b, e); end
    end
    total++;
    if (poll_count !== poll_exp) begin bad++; $display("FAIL rst_resume_poll got=%0d exp=%0d", poll_count, poll_exp); end
  endtask

  task automatic test_turbo();
    logic       b, e;
    logic [7:0] pat;
`ifdef NES_PAD_TURBO_EN
    pat = 8'b0011_0011;
`else
    pat = 8'b0000_0000;
`endif
    rst_n = 0; hold(2); rst_n = 1; hold(2);
    sb.delete();
    buttons = 8'h80; turbo_a = 1;
    for (int p = 0; p < 8; p++) begin
      do_latch();
      sb.push_back(pat[7-p]);
      read_bit(b); e = sb.pop_front(); total++;
      if (b !== e) begin bad++; $display("FAIL turbo_poll%0d got=%b exp=%b", p, b, e); end
    end
    turbo_a = 0;
  endtask

  initial begin
    hold(3);
    rst_n = 1;
    hold(2);
    test_reset();
    test_basic();
    test_done();
    test_abort();
    test_same_cycle();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_turbo();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nes_pad_responder.md
# nes_pad_responder

Controller-side end of the NES pad serial protocol: it receives `latch` and `ctrl_clk` from the existing host-side controller reader and shifts out a captured 8-button snapshot on `data`. It lets on-chip sources (CPU player, replay, bench stimulus) drive a player slot through the same pins and reader as a physical pad. It sits between a button source and a `controller` instance's `latch`/`clock`/`data` pins.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for `latch` and `ctrl_clk`; minimum 2.
- `TIMEOUT_CYCLES`, default 1_000_000: `clk` cycles without a latch rising edge before `host_active` drops.
- `TURBO_POLLS`, default 4: polls per turbo half-period. Used only with `NES_PAD_TURBO_EN`.

Ports:
- `clk` in 1: system clock (pixel-clock domain).
- `rst_n` in 1: asynchronous, active-low reset.
- `buttons` in 8: active-high button state. [7]=A, [6]=B, [5]=Select, [4]=Start, [3]=Up, [2]=Down, [1]=Left, [0]=Right.
- `turbo_a` in 1: autofire request for A.
- `turbo_b` in 1: autofire request for B.
- `latch` in 1: host latch, asynchronous to `clk`.
- `ctrl_clk` in 1: host shift clock, asynchronous to `clk`.
- `data` out 1: serial output, active-low (0 = pressed).
- `host_active` out 1: a latch has been seen within `TIMEOUT_CYCLES`.
- `poll_count` out 16: number of completed latch rising edges, wraps.

## Operation
- `latch` and `ctrl_clk` each pass through `SYNC_STAGES` flops, then a one-flop edge detector. All logic below acts on the synchronized signals.
- Shift register `sr[7:0]` holds inverted buttons. `data` = `sr[7]`, registered.
- State machine:
  - IDLE: reset state. `data`=1. A synchronized latch high -> LOAD.
  - LOAD: while latch is high, `sr` <= ~`buttons` every cycle, `bit_cnt` <= 0, and `ctrl_clk` edges are ignored. Latch falling edge -> SHIFT.
  - SHIFT: each `ctrl_clk` rising edge does `sr` <= {`sr[6:0]`, 1'b0} and `bit_cnt`++. On the 8th edge -> DONE.
  - DONE: `data`=0, so extra reads look like a pressed button, as on genuine hardware. Further `ctrl_clk` edges have no effect.
- Latch high in any state forces LOAD, including mid-SHIFT. A partial read is abandoned with no error.
- If a latch rise and a `ctrl_clk` rise land on the same cycle, the latch wins: the load happens and the clock edge is dropped.
- `poll_count` increments on each latch rising edge and wraps from 0xFFFF to 0.
- A watchdog counter resets on each latch rising edge and saturates at `TIMEOUT_CYCLES`. `host_active` = counter < `TIMEOUT_CYCLES` and at least one latch has been seen since reset.
- `buttons` is sampled only in LOAD. Changes during SHIFT do not affect the frame in flight.

## Timing
- Reset values: `data`=1, `host_active`=0, `poll_count`=0, `sr`=8'hFF, `bit_cnt`=0, state IDLE, turbo phase 0, synchronizer flops 0.
- Latch pin rise to LOAD entry: `SYNC_STAGES`+1 `clk` cycles.
- `ctrl_clk` pin rise to new `data` value: `SYNC_STAGES`+2 `clk` cycles (sync, edge detect, registered output).
- Host timing requirement: the `ctrl_clk` high and low phases and the latch pulse each span at least `SYNC_STAGES`+2 `clk` cycles.
- Reset asserted mid-frame returns every output to its reset value asynchronously. The responder resumes at the next latch.

## Configuration
- `NES_PAD_TURBO_EN` defined:
  - A turbo phase bit toggles every `TURBO_POLLS` latch rising edges.
  - While phase=1, bit 7 is loaded as ~(`buttons[7]` & ~`turbo_a`) and bit 6 as ~(`buttons[6]` & ~`turbo_b`). This forces A/B released on alternate periods.
  - While phase=0, A/B load unmodified.
- `NES_PAD_TURBO_EN` undefined: `turbo_a`/`turbo_b` are ignored, no phase logic is synthesized, and `buttons` loads unmodified.

## Test plan
- `buttons`=8'b1000_0001, one latch pulse, 8 `ctrl_clk` pulses -> `data` sequence 0,1,1,1,1,1,1,0; `poll_count`=1.
- After the 8 bits, 3 extra `ctrl_clk` pulses -> `data` stays 0. A new latch with `buttons`=0 -> `data`=1.
- Latch re-asserted after 3 shifts with `buttons`=8'h40 -> first bit after the latch falls is 1 and the second is 0. The aborted frame leaves no residue.
- Latch rise and `ctrl_clk` rise on the same synchronized cycle -> load wins and `bit_cnt`=0. Next, 8 clocks read all 8 bits.
- Latch stops for `TIMEOUT_CYCLES`+1 cycles -> `host_active` falls to 0. The next latch restores it to 1 within `SYNC_STAGES`+2 cycles.
- `rst_n` pulsed low mid-SHIFT -> `data`=1, `poll_count`=0, `host_active`=0 immediately.
- With `NES_PAD_TURBO_EN`, `TURBO_POLLS`=2, A held, `turbo_a`=1 -> the first `data` bit over 8 polls is 0,0,1,1,0,0,1,1.
